hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage integer core. It sits beside the forwarding logic and covers the hazards forwarding cannot resolve: load-use, multi-cycle multiply occupancy in EX, data-memory wait and taken-branch flush. It drives every stage write-enable, bubble and flush signal from one place, so stall and flush priority is defined in a single block.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/hazard_perf_cnt.sv | 24 ++
 rtl/hazard_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the integer core pipeline control blocks:
// hazard FSM states, the architectural zero register and default multiply latency.
package core_pkg;

    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MUL_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MUL_LAT_DEFAULT = 3;

    // One bundle for every stage-register control, so each priority case
    // assigns a complete, self-describing set of controls.
    typedef struct packed {
        logic pc_write_en;
        logic if_id_write_en;
        logic if_id_flush;
        logic id_ex_write_en;
        logic id_ex_bubble;
        logic ex_mem_write_en;
        logic ex_mem_bubble;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_RUN = '{
        pc_write_en:     1'b1,
        if_id_write_en:  1'b1,
        if_id_flush:     1'b0,
        id_ex_write_en:  1'b1,
        id_ex_bubble:    1'b0,
        ex_mem_write_en: 1'b1,
        ex_mem_bubble:   1'b0,
        mem_wb_bubble:   1'b0
    };

    localparam hz_ctrl_t HZ_CTRL_RESET = '{
        pc_write_en:     1'b0,
        if_id_write_en:  1'b0,
        if_id_flush:     1'b1,
        id_ex_write_en:  1'b0,
        id_ex_bubble:    1'b1,
        ex_mem_write_en: 1'b0,
        ex_mem_bubble:   1'b1,
        mem_wb_bubble:   1'b1
    };

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and branch-flush event counters for the hazard controller.
// Only instantiated when HAZARD_PERF_EN is defined; both counters wrap.
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_evt,
    input  logic              flush_evt,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall_evt) perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
            if (flush_evt) perf_flushes      <= perf_flushes + PERF_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core: memory wait, multiply
// occupancy, taken-branch flush and load-use. Optional counters: HAZARD_PERF_EN.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int CNT_W   = 4
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W  = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_memread,
    input  logic       id_ex_is_mul,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write_en,
    output logic       if_id_write_en,
    output logic       if_id_flush,
    output logic       id_ex_write_en,
    output logic       id_ex_bubble,
    output logic       ex_mem_write_en,
    output logic       ex_mem_bubble,
    output logic       mem_wb_bubble,
    output logic       mul_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    localparam bit             MUL_STALL_EN = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    hz_ctrl_t         ctrl;

    logic mem_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mul_start;
    logic mul_stall;
    logic br_flush;
    logic lu_stall;

    // Hazard detection, already resolved into strict priority order.
    assign mem_stall = mem_req & ~mem_ready;
    assign rs1_hit   = id_uses_rs1 & (id_ex_rd == id_rs1);
    assign rs2_hit   = id_uses_rs2 & (id_ex_rd == id_rs2);
    assign load_use  = id_ex_memread & (id_ex_rd != REG_ZERO) & (rs1_hit | rs2_hit);
    assign mul_start = MUL_STALL_EN & (state_q == HZ_RUN) & id_ex_is_mul;

    assign mul_stall = ~mem_stall &
                       (mul_start | ((state_q == HZ_MUL_WAIT) & (mul_cnt_q != '0)));
    assign br_flush  = ~mem_stall & ~mul_stall & (state_q == HZ_RUN) & ex_branch_taken;
    assign lu_stall  = ~mem_stall & ~mul_stall & ~br_flush & load_use;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HZ_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a value unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        if (!mem_stall) begin
            unique case (state_q)
                HZ_RUN: begin
                    if (mul_start) begin
                        state_d   = HZ_MUL_WAIT;
                        mul_cnt_d = MUL_LOAD;
                    end
                end
                HZ_MUL_WAIT: begin
                    if (mul_cnt_q != '0) begin
                        mul_cnt_d = mul_cnt_q - CNT_W'(1);
                    end else begin
                        state_d = HZ_RUN;
                    end
                end
                default: state_d = HZ_RUN;
            endcase
        end
    end

    // Reset is folded in here so the pipeline registers see NOPs while held.
    always_comb begin
        ctrl = HZ_CTRL_RUN;
        if (!rst_n) begin
            ctrl = HZ_CTRL_RESET;
        end else if (mem_stall) begin
            ctrl.pc_write_en     = 1'b0;
            ctrl.if_id_write_en  = 1'b0;
            ctrl.id_ex_write_en  = 1'b0;
            ctrl.ex_mem_write_en = 1'b0;
            ctrl.mem_wb_bubble   = 1'b1;
        end else if (mul_stall) begin
            ctrl.pc_write_en    = 1'b0;
            ctrl.if_id_write_en = 1'b0;
            ctrl.id_ex_write_en = 1'b0;
            ctrl.ex_mem_bubble  = 1'b1;
        end else if (br_flush) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
        end else if (lu_stall) begin
            ctrl.pc_write_en    = 1'b0;
            ctrl.if_id_write_en = 1'b0;
            ctrl.id_ex_bubble   = 1'b1;
        end
    end

    assign pc_write_en     = ctrl.pc_write_en;
    assign if_id_write_en  = ctrl.if_id_write_en;
    assign if_id_flush     = ctrl.if_id_flush;
    assign id_ex_write_en  = ctrl.id_ex_write_en;
    assign id_ex_bubble    = ctrl.id_ex_bubble;
    assign ex_mem_write_en = ctrl.ex_mem_write_en;
    assign ex_mem_bubble   = ctrl.ex_mem_bubble;
    assign mem_wb_bubble   = ctrl.mem_wb_bubble;
    assign mul_busy        = rst_n & (state_q == HZ_MUL_WAIT);

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_evt         (~ctrl.pc_write_en),
        .flush_evt         (br_flush),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: dut_a uses MUL_LAT=3, dut_b MUL_LAT=1,
// both driven by the same directed vectors with hand-computed expected controls.
module tb_hazard_stall_ctrl;

    // Bit order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bub,
    //            ex_mem_we, ex_mem_bub, mem_wb_bub, mul_busy
    localparam logic [8:0] RST    = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] IDLE   = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] LU     = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] MULS   = 9'b0_0_0_0_0_1_1_0_0;
    localparam logic [8:0] MULW   = 9'b0_0_0_0_0_1_1_0_1;
    localparam logic [8:0] MULREL = 9'b1_1_0_1_0_1_0_0_1;
    localparam logic [8:0] MEMW   = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] MEMR   = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] BR     = 9'b1_1_1_1_1_1_0_0_0;

    typedef struct {
        string      name;
        logic [8:0] exp_a;
        logic [8:0] exp_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_is_mul;
    logic       ex_branch_taken, mem_req, mem_ready;

    logic pc_we_a, ifid_we_a, ifid_fl_a, idex_we_a, idex_bub_a, exmem_we_a, exmem_bub_a, memwb_bub_a, busy_a;
    logic pc_we_b, ifid_we_b, ifid_fl_b, idex_we_b, idex_bub_b, exmem_we_b, exmem_bub_b, memwb_bub_b, busy_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    exp_t sb[$];
    int   cmp_count = 0;
    int   err_count = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .id_ex_is_mul(id_ex_is_mul),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_we_a), .if_id_write_en(ifid_we_a), .if_id_flush(ifid_fl_a),
        .id_ex_write_en(idex_we_a), .id_ex_bubble(idex_bub_a),
        .ex_mem_write_en(exmem_we_a), .ex_mem_bubble(exmem_bub_a),
        .mem_wb_bubble(memwb_bub_a), .mul_busy(busy_a)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(stall_cnt_a), .perf_flushes(flush_cnt_a)
`endif
    );

    hazard_stall_ctrl #(.MUL_LAT(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .id_ex_is_mul(id_ex_is_mul),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_we_b), .if_id_write_en(ifid_we_b), .if_id_flush(ifid_fl_b),
        .id_ex_write_en(idex_we_b), .id_ex_bubble(idex_bub_b),
        .ex_mem_write_en(exmem_we_b), .ex_mem_bubble(exmem_bub_b),
        .mem_wb_bubble(memwb_bub_b), .mul_busy(busy_b)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(stall_cnt_b), .perf_flushes(flush_cnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        cmp_count++;
        if (actual !== expected) begin
            err_count++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Monitor: every cycle the DUTs present a control vector; compare it
    // against the oldest expectation, mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "/a"}, 32'({pc_we_a, ifid_we_a, ifid_fl_a, idex_we_a, idex_bub_a,
                                          exmem_we_a, exmem_bub_a, memwb_bub_a, busy_a}), 32'(e.exp_a));
                check({e.name, "/b"}, 32'({pc_we_b, ifid_we_b, ifid_fl_b, idex_we_b, idex_bub_b,
                                          exmem_we_b, exmem_bub_b, memwb_bub_b, busy_b}), 32'(e.exp_b));
            end
        end
    end

    // Applies one cycle of inputs just after a rising edge and queues the
    // expected controls for that cycle.
    task automatic step(input string name, input logic rstn,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic mul, input logic br,
                        input logic mreq, input logic mrdy,
                        input logic [8:0] ea, input logic [8:0] eb);
        exp_t e;
        rst_n = rstn; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_ex_rd = rd; id_ex_memread = mr; id_ex_is_mul = mul; ex_branch_taken = br;
        mem_req = mreq; mem_ready = mrdy;
        e.name = name; e.exp_a = ea; e.exp_b = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name, input logic [8:0] ea, input logic [8:0] eb);
        step(name, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ea, eb);
    endtask

    task automatic mul(input string name, input logic [8:0] ea, input logic [8:0] eb);
        step(name, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ea, eb);
    endtask

    initial begin
        rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_ex_rd = '0; id_ex_memread = 0; id_ex_is_mul = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 1;
        @(posedge clk);
        #1;

        step("reset", 1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, RST, RST);
        idle("idle", IDLE, IDLE);

        // Load-use detection and the x0 / uses-flag qualifiers
        step("lu_rs2",  1'b1, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 1, LU, LU);
        idle("after_lu", IDLE, IDLE);
        step("lu_x0",   1'b1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 1, IDLE, IDLE);
        step("lu_nouse", 1'b1, 5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0, 0, 1, IDLE, IDLE);
        step("lu_rs1",  1'b1, 5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, 1, LU, LU);

        // Multiply occupancy: two stall cycles for MUL_LAT=3, none for MUL_LAT=1
        mul("mul_start", MULS, IDLE);
        mul("mul_wait", MULW, IDLE);
        mul("mul_rel", MULREL, IDLE);
        idle("mul_done", IDLE, IDLE);

        // Memory wait freezes MUL_WAIT with mul_cnt=1 for four cycles
        mul("mul2_start", MULS, IDLE);
        step("memw0", 1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, MEMW, MEMR);
        step("memw1_br_lu", 1'b1, 5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 1, 1, 0, MEMW, MEMR);
        step("memw2", 1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, MEMW, MEMR);
        step("memw3", 1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, MEMW, MEMR);
        step("mem_ok", 1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 1, MULW, IDLE);
        mul("mul2_rel", MULREL, IDLE);
        idle("mul2_done", IDLE, IDLE);

        // Branch flush beats a simultaneous load-use without an extra stall
        step("br_lu", 1'b1, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 1, 0, 1, BR, BR);
        idle("after_br", IDLE, IDLE);

        // Back-to-back multiplies re-enter MUL_WAIT from RUN
        mul("b2b_s0", MULS, IDLE);
        mul("b2b_w0", MULW, IDLE);
        mul("b2b_r0", MULREL, IDLE);
        mul("b2b_s1", MULS, IDLE);
        mul("b2b_w1", MULW, IDLE);
        mul("b2b_r1", MULREL, IDLE);
        idle("b2b_done", IDLE, IDLE);

        // Reset in the middle of MUL_WAIT returns to RUN
        mul("rst_mul_s", MULS, IDLE);
        mul("rst_mul_w", MULW, IDLE);
        step("rst_mid", 1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 1, RST, RST);
        idle("rst_rel", IDLE, IDLE);

        // 1 load-use + 2 multiply stalls + 1 flush for the event counters
        step("p_lu", 1'b1, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 1, LU, LU);
        idle("p_idle0", IDLE, IDLE);
        mul("p_mul_s", MULS, IDLE);
        mul("p_mul_w", MULW, IDLE);
        mul("p_mul_r", MULREL, IDLE);
        idle("p_idle1", IDLE, IDLE);
        step("p_br", 1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, BR, BR);
        idle("p_idle2", IDLE, IDLE);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        cmp_count++;
        if (sb.size() != 0) begin
            err_count++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

`ifdef HAZARD_PERF_EN
        check("perf_stall_a", stall_cnt_a, 32'd3);
        check("perf_flush_a", flush_cnt_a, 32'd1);
        check("perf_stall_b", stall_cnt_b, 32'd1);
        check("perf_flush_b", flush_cnt_b, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
